// File: rtl/cma_coeff_update.sv
// CMA coefficient adaptation engine: w_k <- sat(w_k - mu*e*x_k), one tap per clock,
// with a one-cycle update strobe once the whole weight vector has been recomputed.
module cma_coeff_update #(
    parameter int unsigned FIR_LEN     = 21,
    parameter int unsigned NB_COEFF    = 8,
    parameter int unsigned NBF_COEFF   = 7,
    parameter int unsigned NB_X        = 8,
    parameter int unsigned NBF_X       = 7,
    parameter int unsigned NB_ERR      = 10,
    parameter int unsigned NBF_ERR     = 7,
    parameter int unsigned NB_MU       = 4,
    parameter int unsigned CENTRAL_TAP = FIR_LEN / 2
) (
    input  logic                               i_clock,
    input  logic                               i_reset,
    input  logic                               i_valid,
    input  logic signed [NB_ERR-1:0]           i_err,
    input  logic        [FIR_LEN*NB_X-1:0]     i_x_flat,
    input  logic        [FIR_LEN*NB_COEFF-1:0] i_w_flat,
    input  logic        [NB_MU-1:0]            i_mu_shift,
    output logic        [FIR_LEN*NB_COEFF-1:0] o_w_new_flat,
    output logic                               o_update_en,
    output logic                               o_busy,
    output logic        [7:0]                  o_drop_cnt
);

    localparam int unsigned NB_K       = (FIR_LEN > 1) ? $clog2(FIR_LEN) : 1;
    localparam int unsigned NB_PROD    = NB_ERR + NB_X;
    localparam int unsigned NB_SUM     = NB_PROD + 2;
    localparam int unsigned NB_SHIFT   = 8;
    localparam int unsigned BASE_SHIFT = NBF_ERR + NBF_X - NBF_COEFF;
    localparam int unsigned NB_WVEC    = FIR_LEN * NB_COEFF;
    localparam int unsigned NB_XVEC    = FIR_LEN * NB_X;

    localparam logic [NB_K-1:0]            LAST_K  = NB_K'(FIR_LEN - 1);
    localparam logic [NB_COEFF-1:0]        W_ONE   = NB_COEFF'((2 ** NBF_COEFF) - 1);
    localparam logic [NB_COEFF-1:0]        W_MAX   = {1'b0, {(NB_COEFF-1){1'b1}}};
    localparam logic [NB_COEFF-1:0]        W_MIN   = {1'b1, {(NB_COEFF-1){1'b0}}};
    localparam logic signed [NB_SUM-1:0]   SAT_MAX = NB_SUM'(W_MAX);
    localparam logic signed [NB_SUM-1:0]   SAT_MIN = ~SAT_MAX;

    // Reset weight vector: unit gain on the central tap, zero elsewhere
    function automatic logic [NB_WVEC-1:0] reset_weights();
        logic [NB_WVEC-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < FIR_LEN; i++) begin
            if (i == CENTRAL_TAP) v[i*NB_COEFF +: NB_COEFF] = W_ONE;
        end
        return v;
    endfunction

    localparam logic [NB_WVEC-1:0] W_RESET = reset_weights();

    typedef enum logic [1:0] {IDLE, UPDATE, COMMIT} state_t;

    state_t                    state;
    logic [NB_K-1:0]           k;
    logic signed [NB_ERR-1:0]  err_q;
    logic [NB_XVEC-1:0]        x_q;
    logic [NB_WVEC-1:0]        w_q;
    logic [NB_MU-1:0]          mu_q;

    logic                      accept;
    logic signed [NB_X-1:0]    x_k;
    logic signed [NB_COEFF-1:0] w_k;
    logic signed [NB_PROD-1:0] prod;
    logic [NB_SHIFT-1:0]       shamt;
    logic signed [NB_PROD-1:0] delta;
    logic signed [NB_SUM-1:0]  sum;
    logic signed [NB_COEFF-1:0] w_sat;

    assign accept = i_valid && (state == IDLE || state == COMMIT);

    // Select the current tap's regressor and weight from the snapshot
    always_comb begin
        x_k = '0;
        w_k = '0;
        for (int unsigned i = 0; i < FIR_LEN; i++) begin
            if (k == NB_K'(i)) begin
                x_k = x_q[i*NB_X +: NB_X];
                w_k = w_q[i*NB_COEFF +: NB_COEFF];
            end
        end
    end

    // Product and difference are kept at full width so only the final clamp limits range
    assign prod  = NB_PROD'(err_q) * NB_PROD'(x_k);
    assign shamt = NB_SHIFT'(BASE_SHIFT) + NB_SHIFT'(mu_q);
    assign delta = prod >>> shamt;
    assign sum   = NB_SUM'(w_k) - NB_SUM'(delta);

    always_comb begin
        w_sat = sum[NB_COEFF-1:0];
        if (sum > SAT_MAX)      w_sat = W_MAX;
        else if (sum < SAT_MIN) w_sat = W_MIN;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state        <= IDLE;
            k            <= '0;
            err_q        <= '0;
            x_q          <= '0;
            w_q          <= '0;
            mu_q         <= '0;
            o_w_new_flat <= W_RESET;
            o_update_en  <= 1'b0;
            o_busy       <= 1'b0;
            o_drop_cnt   <= '0;
        end else begin
            o_update_en <= 1'b0;
            if (accept) begin
                err_q  <= i_err;
                x_q    <= i_x_flat;
                w_q    <= i_w_flat;
                mu_q   <= i_mu_shift;
                k      <= '0;
                state  <= UPDATE;
                o_busy <= 1'b1;
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    UPDATE: begin
                        for (int unsigned i = 0; i < FIR_LEN; i++) begin
                            if (k == NB_K'(i)) o_w_new_flat[i*NB_COEFF +: NB_COEFF] <= w_sat;
                        end
                        // Samples arriving mid-computation are counted and discarded
                        if (i_valid && o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'd1;
                        if (k == LAST_K) begin
                            state       <= COMMIT;
                            o_update_en <= 1'b1;
                            o_busy      <= 1'b0;
                        end else begin
                            k <= k + NB_K'(1);
                        end
                    end
                    COMMIT: state <= IDLE;
                    default: begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cma_coeff_update.sv
// Directed and randomized bench for cma_coeff_update, checked against an integer model
// of the per-tap CMA update rule.
module tb_cma_coeff_update;

    localparam int FIR_LEN   = 21;
    localparam int NB_COEFF  = 8;
    localparam int NBF_COEFF = 7;
    localparam int NB_X      = 8;
    localparam int NBF_X     = 7;
    localparam int NB_ERR    = 10;
    localparam int NBF_ERR   = 7;
    localparam int NB_MU     = 4;
    localparam int W_BITS    = FIR_LEN * NB_COEFF;
    localparam int X_BITS    = FIR_LEN * NB_X;
    localparam int LATENCY   = FIR_LEN;
    localparam int W_HI      = (2 ** (NB_COEFF - 1)) - 1;
    localparam int W_LO      = -(2 ** (NB_COEFF - 1));

    logic              i_clock = 1'b0;
    logic              i_reset;
    logic              i_valid;
    logic [NB_ERR-1:0] i_err;
    logic [X_BITS-1:0] i_x_flat;
    logic [W_BITS-1:0] i_w_flat;
    logic [NB_MU-1:0]  i_mu_shift;
    logic [W_BITS-1:0] o_w_new_flat;
    logic              o_update_en;
    logic              o_busy;
    logic [7:0]        o_drop_cnt;

    cma_coeff_update dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_valid      (i_valid),
        .i_err        (i_err),
        .i_x_flat     (i_x_flat),
        .i_w_flat     (i_w_flat),
        .i_mu_shift   (i_mu_shift),
        .o_w_new_flat (o_w_new_flat),
        .o_update_en  (o_update_en),
        .o_busy       (o_busy),
        .o_drop_cnt   (o_drop_cnt)
    );

    always #5 i_clock = ~i_clock;

    int checks   = 0;
    int errors   = 0;
    int exp_drop = 0;
    int e_v;
    int mu_v;
    int x_a [FIR_LEN];
    int w_a [FIR_LEN];
    int exp_a [FIR_LEN];

    task automatic chk(input string tag, input logic [W_BITS-1:0] obs, input logic [W_BITS-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: w - floor(e*x / 2^(frac_e+frac_x-frac_w+mu)), clamped to the coefficient range
    function automatic void model();
        for (int t = 0; t < FIR_LEN; t++) begin
            int p, d, s;
            p = e_v * x_a[t];
            d = p >>> (NBF_ERR + NBF_X - NBF_COEFF + mu_v);
            s = w_a[t] - d;
            if (s > W_HI) s = W_HI;
            if (s < W_LO) s = W_LO;
            exp_a[t] = s;
        end
    endfunction

    function automatic logic [W_BITS-1:0] pack_exp();
        logic [W_BITS-1:0] v;
        for (int t = 0; t < FIR_LEN; t++) v[t*NB_COEFF +: NB_COEFF] = NB_COEFF'(exp_a[t]);
        return v;
    endfunction

    function automatic logic [W_BITS-1:0] uniform_vec(input int val);
        logic [W_BITS-1:0] v;
        for (int t = 0; t < FIR_LEN; t++) v[t*NB_COEFF +: NB_COEFF] = NB_COEFF'(val);
        return v;
    endfunction

    function automatic logic [W_BITS-1:0] reset_vec();
        logic [W_BITS-1:0] v;
        v = '0;
        v[(FIR_LEN/2)*NB_COEFF +: NB_COEFF] = NB_COEFF'(127);
        return v;
    endfunction

    task automatic set_uniform(input int e, input int xv, input int wv, input int mu);
        e_v  = e;
        mu_v = mu;
        for (int t = 0; t < FIR_LEN; t++) begin
            x_a[t] = xv;
            w_a[t] = wv;
        end
    endtask

    task automatic set_random();
        e_v  = int'($urandom_range(0, 1023)) - 512;
        mu_v = int'($urandom_range(0, 15));
        for (int t = 0; t < FIR_LEN; t++) begin
            x_a[t] = int'($urandom_range(0, 255)) - 128;
            w_a[t] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    task automatic drive_inputs();
        i_err      = NB_ERR'(e_v);
        i_mu_shift = NB_MU'(mu_v);
        for (int t = 0; t < FIR_LEN; t++) begin
            i_x_flat[t*NB_X +: NB_X]         = NB_X'(x_a[t]);
            i_w_flat[t*NB_COEFF +: NB_COEFF] = NB_COEFF'(w_a[t]);
        end
    endtask

    task automatic scramble();
        i_err      = NB_ERR'($urandom);
        i_mu_shift = NB_MU'($urandom);
        for (int t = 0; t < FIR_LEN; t++) begin
            i_x_flat[t*NB_X +: NB_X]         = NB_X'($urandom);
            i_w_flat[t*NB_COEFF +: NB_COEFF] = NB_COEFF'($urandom);
        end
    endtask

    // Present the current stimulus for one cycle, then garble the inputs
    task automatic accept();
        @(negedge i_clock);
        drive_inputs();
        i_valid = 1'b1;
        @(negedge i_clock);
        i_valid = 1'b0;
        scramble();
    endtask

    // Count edges until the strobe; mode 1 pulses i_valid 3 times, mode 2 every cycle
    task automatic wait_upd(input int mode, output int n, output bit busy_ok);
        int nd;
        n = 0;
        nd = 0;
        busy_ok = 1'b1;
        while (n < 3 * LATENCY) begin
            @(negedge i_clock);
            n++;
            if (o_update_en) break;
            if (!o_busy) busy_ok = 1'b0;
            if ((mode == 1 && (n == 2 || n == 5 || n == 9)) || mode == 2) begin
                i_valid = 1'b1;
                nd++;
            end else begin
                i_valid = 1'b0;
            end
            scramble();
        end
        i_valid = 1'b0;
        exp_drop = (exp_drop + nd > 255) ? 255 : exp_drop + nd;
    endtask

    task automatic run_txn(input string tag, input int mode, input logic [W_BITS-1:0] expv);
        int n;
        bit ok;
        accept();
        chk({tag, "_busy_start"}, W_BITS'(o_busy), W_BITS'(1));
        wait_upd(mode, n, ok);
        chk({tag, "_latency"}, W_BITS'(n), W_BITS'(LATENCY));
        chk({tag, "_busy_during"}, W_BITS'(ok), W_BITS'(1));
        chk({tag, "_update_en"}, W_BITS'(o_update_en), W_BITS'(1));
        chk({tag, "_busy_commit"}, W_BITS'(o_busy), W_BITS'(0));
        chk({tag, "_weights"}, o_w_new_flat, expv);
        chk({tag, "_drop_cnt"}, W_BITS'(o_drop_cnt), W_BITS'(exp_drop));
    endtask

    task automatic end_strobe(input string tag);
        @(negedge i_clock);
        chk({tag, "_strobe_end"}, W_BITS'(o_update_en), W_BITS'(0));
    endtask

    initial begin
        logic [W_BITS-1:0] ev;
        logic [W_BITS-1:0] first_res;
        int n;
        bit ok;
        bit saw;

        i_reset = 1'b1;
        i_valid = 1'b0;
        scramble();
        repeat (3) @(negedge i_clock);
        chk("rst_update_en", W_BITS'(o_update_en), W_BITS'(0));
        chk("rst_busy", W_BITS'(o_busy), W_BITS'(0));
        chk("rst_drop_cnt", W_BITS'(o_drop_cnt), W_BITS'(0));
        chk("rst_weights", o_w_new_flat, reset_vec());
        i_reset = 1'b0;

        // Zero error leaves the weights untouched
        set_random();
        e_v = 0;
        for (int t = 0; t < FIR_LEN; t++) begin
            w_a[t] = t;
            ev[t*NB_COEFF +: NB_COEFF] = NB_COEFF'(t);
        end
        run_txn("zero_err", 0, ev);
        end_strobe("zero_err");

        set_uniform(128, 64, 0, 0);
        run_txn("mu0", 0, uniform_vec(-64));
        end_strobe("mu0");
        set_uniform(128, 64, 0, 3);
        run_txn("mu3", 0, uniform_vec(-8));
        end_strobe("mu3");
        set_uniform(-1, 1, 0, 0);
        run_txn("floor", 0, uniform_vec(1));
        end_strobe("floor");
        set_uniform(-128, -128, -128, 0);
        run_txn("sat_lo", 0, uniform_vec(-128));
        end_strobe("sat_lo");
        set_uniform(-128, 127, 127, 0);
        run_txn("sat_hi", 0, uniform_vec(127));
        end_strobe("sat_hi");

        // Same data undisturbed and with three rejected pulses must agree
        set_random();
        model();
        first_res = pack_exp();
        run_txn("undisturbed", 0, first_res);
        end_strobe("undisturbed");
        run_txn("dropped3", 1, first_res);
        end_strobe("dropped3");

        // Back-to-back accept in the commit cycle
        set_random();
        model();
        run_txn("b2b_first", 0, pack_exp());
        set_random();
        model();
        drive_inputs();
        i_valid = 1'b1;
        @(negedge i_clock);
        i_valid = 1'b0;
        scramble();
        wait_upd(0, n, ok);
        chk("b2b_spacing", W_BITS'(n + 1), W_BITS'(LATENCY + 1));
        chk("b2b_busy", W_BITS'(ok), W_BITS'(1));
        chk("b2b_weights", o_w_new_flat, pack_exp());
        end_strobe("b2b");

        for (int r = 0; r < 6; r++) begin
            set_random();
            model();
            run_txn($sformatf("rand%0d", r), 0, pack_exp());
            end_strobe($sformatf("rand%0d", r));
        end

        // Drive the drop counter into saturation
        for (int r = 0; r < 13; r++) begin
            set_random();
            model();
            run_txn($sformatf("dropsat%0d", r), 2, pack_exp());
            end_strobe($sformatf("dropsat%0d", r));
        end

        // Reset in the middle of an update aborts it
        set_random();
        model();
        accept();
        repeat (10) @(negedge i_clock);
        #2 i_reset = 1'b1;
        @(negedge i_clock);
        exp_drop = 0;
        chk("midrst_update_en", W_BITS'(o_update_en), W_BITS'(0));
        chk("midrst_busy", W_BITS'(o_busy), W_BITS'(0));
        chk("midrst_drop_cnt", W_BITS'(o_drop_cnt), W_BITS'(0));
        chk("midrst_weights", o_w_new_flat, reset_vec());
        i_reset = 1'b0;
        saw = 1'b0;
        repeat (2 * LATENCY) begin
            @(negedge i_clock);
            if (o_update_en) saw = 1'b1;
        end
        chk("midrst_no_strobe", W_BITS'(saw), W_BITS'(0));
        chk("midrst_weights_hold", o_w_new_flat, reset_vec());

        set_random();
        model();
        run_txn("post_rst", 0, pack_exp());
        end_strobe("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cma_coeff_update.md
Name: cma_coeff_update

Overview:
Constant-modulus adaptation engine that computes the next FIR coefficient set and feeds the coefficient register bank directly downstream.
- The upstream slicer/error stage supplies one CMA error sample per symbol, together with the FIR regressor snapshot.
- On each accepted sample the block processes one tap per clock: w_k <- sat(w_k - mu*e*x_k).
- When all taps are done it pulses a one-cycle update strobe alongside the complete new weight vector.

Parameters:
FIR_LEN, 21, number of taps
NB_COEFF, 8, coefficient width (signed)
NBF_COEFF, 7, coefficient fractional bits
NB_X, 8, regressor sample width (signed)
NBF_X, 7, regressor fractional bits
NB_ERR, 10, CMA error width (signed)
NBF_ERR, 7, error fractional bits; NBF_ERR+NBF_X >= NBF_COEFF required
NB_MU, 4, width of step-size shift
CENTRAL_TAP, FIR_LEN/2, tap index holding ~1.0 at reset

Ports:
i_clock  in  1  single system clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_valid  in  1  one-cycle qualifier for i_err/i_x_flat
i_err  in  NB_ERR  signed CMA error e = y(|y|^2 - R)
i_x_flat  in  FIR_LEN*NB_X  regressor taps; tap k at [k*NB_X +: NB_X]
i_w_flat  in  FIR_LEN*NB_COEFF  current weights from the coefficient bank
i_mu_shift  in  NB_MU  step size mu = 2^-i_mu_shift
o_w_new_flat  out  FIR_LEN*NB_COEFF  computed weights; tap k at [k*NB_COEFF +: NB_COEFF]
o_update_en  out  1  one-cycle strobe: o_w_new_flat is valid, load it
o_busy  out  1  high while taps are being processed
o_drop_cnt  out  8  saturating count of i_valid pulses rejected while busy

Behaviour:
- Reset (async, i_reset=1):
  - state IDLE, tap index 0, o_update_en=0, o_busy=0, o_drop_cnt=0.
  - o_w_new_flat: tap CENTRAL_TAP = 2^NBF_COEFF-1 (127), all other taps 0.
  - Reset asserted mid-UPDATE aborts the computation; no o_update_en is emitted.
- States:
  - IDLE -> UPDATE when i_valid=1.
  - UPDATE: k runs 0..FIR_LEN-1, one tap per edge. On the edge that writes tap FIR_LEN-1 -> COMMIT.
  - COMMIT: o_update_en=1 for exactly this cycle. Then -> UPDATE if i_valid=1 (back-to-back accept), else -> IDLE.
- Acceptance (IDLE or COMMIT with i_valid=1): latch i_err, i_x_flat, i_w_flat and i_mu_shift into snapshot registers. Later input changes have no effect on the current computation.
- i_valid=1 while in UPDATE: sample dropped, o_drop_cnt += 1, saturating at 255. The computation in progress is unaffected.
- Latency: the sampling edge is edge t; o_update_en is high in the cycle following edge t+FIR_LEN (t+21 by default). Minimum update period is FIR_LEN+1 cycles.
- o_busy = (state == UPDATE).
- Per-tap arithmetic, all signed:
  - p = e * x_k, full width NB_ERR+NB_X, NBF_ERR+NBF_X fractional bits.
  - d = p >>> (NBF_ERR+NBF_X-NBF_COEFF + mu_shift): arithmetic shift, floor rounding, no added rounding constant.
  - s = w_k - d, computed at sufficient width; no intermediate wrap.
  - Saturate s to [-2^(NB_COEFF-1), 2^(NB_COEFF-1)-1], i.e. [-128, 127], and write to o_w_new_flat tap k.
- o_w_new_flat is written tap by tap during UPDATE. It is only guaranteed coherent while o_update_en=1, and holds its value until the next computation overwrites it.
- Downstream rule: the bank must load only on o_update_en. The i_w_flat snapshot means an external weight change during UPDATE is ignored until the next accept.

Test Plan:
- Reset -> o_update_en=0, o_busy=0, o_drop_cnt=0; o_w_new_flat tap10=127, all other taps 0.
- i_err=0, i_w_flat tap k = k, i_valid at edge t -> o_busy high from t to t+21; o_update_en high only in the cycle after edge t+21; o_w_new_flat tap k = k.
- mu_shift=0, e=128 (1.0), all x=64 (0.5), w=0 -> every tap = -64. Same with mu_shift=3 -> every tap = -8. e=-1, x=1, w=0, mu_shift=0 -> every tap = +1 (floor).
- Saturation:
  - w=-128, e=-128, x=-128 -> -128 (not -256).
  - w=127, e=-128, x=127 -> 127 (not 254).
- i_valid pulsed 3 times during UPDATE -> o_drop_cnt=3, result identical to the undisturbed run. i_valid asserted during COMMIT -> accepted; second o_update_en arrives exactly 22 cycles after the first.
- i_reset asserted at k=10 of UPDATE, then released -> no o_update_en, outputs return to reset values, next i_valid behaves as from a fresh reset.
